// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: FSM states, fault codes
// and operation priority decode.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'b00,
        FLT_ALIGN = 2'b01,
        FLT_BUS   = 2'b10
    } fault_e;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LD  = 3'd1,
        OP_STR = 3'd2,
        OP_ALU = 3'd3,
        OP_CMP = 3'd4,
        OP_JMP = 3'd5
    } op_e;

    // Bit positions inside op_flags, highest priority first.
    localparam int OPB_LD  = 4;
    localparam int OPB_STR = 3;
    localparam int OPB_ALU = 2;
    localparam int OPB_CMP = 1;
    localparam int OPB_JMP = 0;

    function automatic op_e decode_op(input logic [4:0] flags);
        op_e op;
        op = OP_NOP;
        if (flags[OPB_LD])       op = OP_LD;
        else if (flags[OPB_STR]) op = OP_STR;
        else if (flags[OPB_ALU]) op = OP_ALU;
        else if (flags[OPB_CMP]) op = OP_CMP;
        else if (flags[OPB_JMP]) op = OP_JMP;
        return op;
    endfunction

endpackage

// File: rtl/mem_access_timer.sv
// Wait counter for the MEM state; expired marks the last allowed
// MEM cycle so an ack in that same cycle can still win.
module mem_timer
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign expired = enable & (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = 8'd0;
        else if (enable && !expired)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores to data memory and
// presents a writeback bundle with register, CPSR and PC write enables.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  op_flags,
    input  logic [3:0]  rd_num,
    input  logic [31:0] rd_val,
    input  logic [31:0] result,
    input  logic [3:0]  nzcv,
    input  logic        taken,
    input  logic [31:0] md,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  wb_rd_num,
    output logic [31:0] wb_val,
    output logic        wb_reg_we,
    output logic        wb_cpsr_we,
    output logic        pc_we,
    output logic [31:0] wb_cpsr,
    output logic [31:0] pc_target,
    output logic [1:0]  fault
);

    state_e      state_q, state_d;
    fault_e      fault_q, fault_d;
    op_e         op_q;
    logic [3:0]  rd_q;
    logic [31:0] wdata_q;
    logic [31:0] res_q;
    logic [3:0]  nzcv_q;
    logic        taken_q;
    logic [31:0] md_q;
    logic [31:0] val_q;

    logic   is_idle, is_mem, is_done;
    logic   accept, tmr_clear, tmr_expired, load_rdata;
    op_e    op_in;
    logic   in_memop, in_misal;
    state_e acc_state;
    fault_e acc_fault;

    assign is_idle = (state_q == ST_IDLE);
    assign is_mem  = (state_q == ST_MEM);
    assign is_done = (state_q == ST_DONE);

    assign in_ready = rst_n & (is_idle | (is_done & out_ready));
    assign accept   = in_valid & in_ready;

    assign op_in    = decode_op(op_flags);
    assign in_memop = (op_in == OP_LD) | (op_in == OP_STR);
    assign in_misal = (result[1:0] != 2'b00);

    always_comb begin
        acc_state = ST_DONE;
        acc_fault = FLT_NONE;
        if (in_memop && in_misal)
            acc_fault = FLT_ALIGN;
        else if (in_memop)
            acc_state = ST_MEM;
    end

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        tmr_clear  = 1'b0;
        load_rdata = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (is_done && out_ready)
                    state_d = ST_IDLE;
                if (accept) begin
                    state_d   = acc_state;
                    fault_d   = acc_fault;
                    tmr_clear = 1'b1;
                end
            end
            ST_MEM: begin
                // Ack is tested first so it beats a same-cycle timeout.
                if (dmem_ack) begin
                    state_d    = ST_DONE;
                    fault_d    = FLT_NONE;
                    load_rdata = (op_q == OP_LD);
                end else if (tmr_expired) begin
                    state_d = ST_DONE;
                    fault_d = FLT_BUS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            rd_q    <= 4'd0;
            wdata_q <= 32'd0;
            res_q   <= 32'd0;
            nzcv_q  <= 4'd0;
            taken_q <= 1'b0;
            md_q    <= 32'd0;
            val_q   <= 32'd0;
        end else if (accept) begin
            op_q    <= op_in;
            rd_q    <= rd_num;
            wdata_q <= rd_val;
            res_q   <= result;
            nzcv_q  <= nzcv;
            taken_q <= taken;
            md_q    <= md;
            val_q   <= result;
        end else if (load_rdata) begin
            val_q   <= dmem_rdata;
        end
    end

    mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (is_mem),
        .expired (tmr_expired)
    );

    logic wb_ok;
    assign wb_ok = is_done & (fault_q == FLT_NONE);

    assign dmem_req   = is_mem;
    assign dmem_we    = is_mem & (op_q == OP_STR);
    assign dmem_addr  = is_mem ? {res_q[31:2], 2'b00} : 32'd0;
    assign dmem_wdata = is_mem ? wdata_q : 32'd0;

    assign out_valid  = is_done;
    assign wb_rd_num  = is_done ? rd_q : 4'd0;
    assign wb_val     = is_done ? val_q : 32'd0;
    assign wb_cpsr    = is_done ? {28'd0, nzcv_q} : 32'd0;
    assign pc_target  = is_done ? md_q : 32'd0;
    assign fault      = is_done ? fault_q : FLT_NONE;
    assign wb_reg_we  = wb_ok & ((op_q == OP_ALU) | (op_q == OP_LD));
    assign wb_cpsr_we = wb_ok & (op_q == OP_CMP);
    assign pc_we      = wb_ok & (op_q == OP_JMP) & taken_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of single-cycle ops plus
// hand-written memory, timeout, stall and reset sequences.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  op_flags;
    logic [3:0]  rd_num;
    logic [31:0] rd_val, result, md;
    logic [3:0]  nzcv;
    logic        taken;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        out_valid, out_ready;
    logic [3:0]  wb_rd_num;
    logic [31:0] wb_val, wb_cpsr, pc_target;
    logic        wb_reg_we, wb_cpsr_we, pc_we;
    logic [1:0]  fault;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_flags   (op_flags),
        .rd_num     (rd_num),
        .rd_val     (rd_val),
        .result     (result),
        .nzcv       (nzcv),
        .taken      (taken),
        .md         (md),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .wb_rd_num  (wb_rd_num),
        .wb_val     (wb_val),
        .wb_reg_we  (wb_reg_we),
        .wb_cpsr_we (wb_cpsr_we),
        .pc_we      (pc_we),
        .wb_cpsr    (wb_cpsr),
        .pc_target  (pc_target),
        .fault      (fault)
    );

    typedef struct {
        logic [4:0]  flags;
        logic [3:0]  rd;
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic        tk;
        logic [31:0] md;
        logic        reg_we;
        logic        cpsr_we;
        logic        pc_we;
        logic [1:0]  flt;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] f, input logic [3:0] rd,
                         input logic [31:0] rv, input logic [31:0] res,
                         input logic [3:0] n, input logic tk,
                         input logic [31:0] m);
        in_valid = 1'b1;
        op_flags = f;
        rd_num   = rd;
        rd_val   = rv;
        result   = res;
        nzcv     = n;
        taken    = tk;
        md       = m;
    endtask

    task automatic run_vec(input vec_t v, input int i);
        string s;
        s = $sformatf("v%0d", i);
        out_ready = 1'b1;
        drive(v.flags, v.rd, 32'h0, v.res, v.nzcv, v.tk, v.md);
        #1 chk({s, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk({s, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({s, ".reg_we"}, 32'(wb_reg_we), 32'(v.reg_we));
        chk({s, ".cpsr_we"}, 32'(wb_cpsr_we), 32'(v.cpsr_we));
        chk({s, ".pc_we"}, 32'(pc_we), 32'(v.pc_we));
        chk({s, ".fault"}, 32'(fault), 32'(v.flt));
        chk({s, ".dmem_req"}, 32'(dmem_req), 32'd0);
        chk({s, ".cpsr"}, wb_cpsr, {28'd0, v.nzcv});
        chk({s, ".pc_target"}, pc_target, v.md);
        if (v.reg_we) begin
            chk({s, ".wb_val"}, wb_val, v.res);
            chk({s, ".wb_rd"}, 32'(wb_rd_num), 32'(v.rd));
        end
        step();
        chk({s, ".idle"}, 32'(out_valid), 32'd0);
    endtask

    int n;

    initial begin
        vt[0] = '{5'b00100, 4'd3, 32'h1234, 4'h0, 1'b0, 32'h0,
                  1'b1, 1'b0, 1'b0, 2'b00};
        vt[1] = '{5'b00111, 4'd5, 32'hAAAA, 4'h5, 1'b1, 32'h10,
                  1'b1, 1'b0, 1'b0, 2'b00};
        vt[2] = '{5'b00011, 4'd1, 32'h0, 4'hA, 1'b1, 32'h20,
                  1'b0, 1'b1, 1'b0, 2'b00};
        vt[3] = '{5'b00001, 4'd2, 32'h0, 4'h0, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b1, 2'b00};
        vt[4] = '{5'b00001, 4'd2, 32'h0, 4'h0, 1'b0, 32'h80,
                  1'b0, 1'b0, 1'b0, 2'b00};
        vt[5] = '{5'b00000, 4'd9, 32'h55, 4'h3, 1'b1, 32'h4,
                  1'b0, 1'b0, 1'b0, 2'b00};
        vt[6] = '{5'b01000, 4'd4, 32'h102, 4'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 2'b01};
        vt[7] = '{5'b10000, 4'd4, 32'h101, 4'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 2'b01};
        vt[8] = '{5'b10111, 4'd6, 32'h3, 4'h1, 1'b1, 32'h8,
                  1'b0, 1'b0, 1'b0, 2'b01};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(5'b0, 4'd0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        in_valid = 1'b0;
        step();
        step();
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.wb_val", wb_val, 32'd0);
        rst_n = 1'b1;
        #1 chk("rel.in_ready", 32'(in_ready), 32'd1);
        step();

        for (int i = 0; i < 9; i++)
            run_vec(vt[i], i);

        // load, ack in the third MEM cycle
        out_ready = 1'b1;
        drive(5'b10000, 4'd8, 32'h0, 32'h100, 4'h0, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        n = 0;
        while (dmem_req && n < 20) begin
            n++;
            chk("ld.we", 32'(dmem_we), 32'd0);
            chk("ld.addr", dmem_addr, 32'h100);
            if (n == 3) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            step();
            dmem_ack = 1'b0;
            dmem_rdata = 32'h0;
            #1;
        end
        chk("ld.req_cycles", 32'(n), 32'd3);
        chk("ld.out_valid", 32'(out_valid), 32'd1);
        chk("ld.wb_val", wb_val, 32'hDEADBEEF);
        chk("ld.reg_we", 32'(wb_reg_we), 32'd1);
        chk("ld.wb_rd", 32'(wb_rd_num), 32'd8);
        chk("ld.fault", 32'(fault), 32'd0);
        step();

        // aligned store, ack in first MEM cycle
        drive(5'b01000, 4'd2, 32'h55AA, 32'h104, 4'h0, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("st.req", 32'(dmem_req), 32'd1);
        chk("st.we", 32'(dmem_we), 32'd1);
        chk("st.wdata", dmem_wdata, 32'h55AA);
        chk("st.addr", dmem_addr, 32'h104);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        #1;
        chk("st.out_valid", 32'(out_valid), 32'd1);
        chk("st.reg_we", 32'(wb_reg_we), 32'd0);
        chk("st.fault", 32'(fault), 32'd0);
        chk("st.req_off", 32'(dmem_req), 32'd0);
        step();

        // load without ack: bus timeout after 4 MEM cycles
        drive(5'b10000, 4'd1, 32'h0, 32'h200, 4'h0, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        n = 0;
        while (dmem_req && n < 20) begin
            n++;
            step();
        end
        chk("to.req_cycles", 32'(n), 32'd4);
        chk("to.out_valid", 32'(out_valid), 32'd1);
        chk("to.fault", 32'(fault), 32'd2);
        chk("to.reg_we", 32'(wb_reg_we), 32'd0);
        step();

        // ack in the fourth MEM cycle beats the timeout
        drive(5'b10000, 4'd1, 32'h0, 32'h200, 4'h0, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        n = 0;
        while (dmem_req && n < 20) begin
            n++;
            if (n == 4) begin
                dmem_ack = 1'b1;
                dmem_rdata = 32'hCAFE0004;
            end
            step();
            dmem_ack = 1'b0;
            #1;
        end
        chk("tw.req_cycles", 32'(n), 32'd4);
        chk("tw.fault", 32'(fault), 32'd0);
        chk("tw.wb_val", wb_val, 32'hCAFE0004);
        chk("tw.reg_we", 32'(wb_reg_we), 32'd1);
        step();

        // taken jump held by out_ready=0, then back-to-back accept
        out_ready = 1'b0;
        drive(5'b00001, 4'd0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("jst.out_valid", 32'(out_valid), 32'd1);
            chk("jst.pc_we", 32'(pc_we), 32'd1);
            chk("jst.pc_target", pc_target, 32'h40);
            chk("jst.in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        drive(5'b00100, 4'd7, 32'h0, 32'h77, 4'h0, 1'b0, 32'h0);
        #1 chk("b2b.in_ready", 32'(in_ready), 32'd1);
        chk("b2b.pc_we", 32'(pc_we), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b.out_valid", 32'(out_valid), 32'd1);
        chk("b2b.wb_val", wb_val, 32'h77);
        chk("b2b.wb_rd", 32'(wb_rd_num), 32'd7);
        chk("b2b.pc_we_off", 32'(pc_we), 32'd0);
        step();

        // reset during MEM drops dmem_req asynchronously
        drive(5'b10000, 4'd3, 32'h0, 32'h300, 4'h0, 1'b0, 32'h0);
        step();
        in_valid = 1'b0;
        chk("rm.req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rm.req_async", 32'(dmem_req), 32'd0);
        chk("rm.out_valid", 32'(out_valid), 32'd0);
        step();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h11111111;
        step();
        dmem_ack = 1'b0;
        chk("rm.late_ack", 32'(out_valid), 32'd0);
        chk("rm.req_idle", 32'(dmem_req), 32'd0);
        run_vec(vt[0], 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
